// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver, half-bit start check, ready/valid word output.
//            Optional 2-of-3 sample voting when UART_RX_MAJORITY_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115_200,
    parameter int CLK_FREQ   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ena,
    input  logic                  rx_signal,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_frame_err,
    output logic                  rx_overrun
);

    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
    localparam int IDX_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] c_pulse_load = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_half_load  = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_line;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_expire;
    logic                  w_sample;
    logic                  w_deliver;
    logic                  w_frame_bad;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else if (ena) begin
            r_sync1 <= rx_signal;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line   = r_sync2;
    assign w_expire = (r_cnt == '0);

`ifdef UART_RX_MAJORITY_EN
    // r_hist[0] is the centre sample; the live line value is the +1 neighbour.
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hist <= 2'b11;
        end else if (ena) begin
            r_hist <= {r_hist[0], w_line};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_line) | (r_hist[0] & w_line);
`else
    assign w_sample = w_line;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_deliver    = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_line) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_expire) begin
                    w_state_next = w_sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_expire && (r_idx == c_last_idx)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_expire) begin
                    if (w_sample) begin
                        w_deliver    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_bad  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_line) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_line) begin
                        r_cnt <= c_half_load;
                    end
                end
                S_START: begin
                    if (w_expire) begin
                        r_cnt <= c_pulse_load;
                        r_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_expire) begin
                        r_shift[r_idx] <= w_sample;
                        r_cnt          <= c_pulse_load;
                        r_idx          <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (!w_expire) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A word arriving while the old one is still held is dropped, not queued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else if (ena) begin
            rx_frame_err <= w_frame_bad;
            rx_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= r_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed frames against a frame-level timing model of uart_rx.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int DW       = 8;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int P        = CLK_FREQ / BAUD;
    localparam int H        = P / 2;
    // Enabled cycles from driving the start bit to the stop-sample edge.
    localparam int LAT      = 3 + H + (DW + 1) * P;

    logic          clk          = 1'b0;
    logic          reset_n      = 1'b0;
    logic          ena          = 1'b1;
    logic          rx_signal    = 1'b1;
    logic          rx_ready     = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_overrun;

    uart_rx #(
        .DATA_WIDTH (DW),
        .BAUD_RATE  (BAUD),
        .CLK_FREQ   (CLK_FREQ)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ena          (ena),
        .rx_signal    (rx_signal),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            t;
        logic [DW-1:0] w;
        bit            stop;
    } ev_t;

    ev_t           evq[$];
    ev_t           mdl_ev;
    bit            mdl_deliver;
    int            tick    = 0;
    logic [DW-1:0] m_data  = '0;
    bit            m_valid = 1'b0;
    bit            m_ferr  = 1'b0;
    bit            m_ov    = 1'b0;

    // Frame-level model: each scheduled frame resolves at its stop-sample tick.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_data  = '0;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ov    = 1'b0;
            evq.delete();
        end else if (ena) begin
            tick        = tick + 1;
            m_ferr      = 1'b0;
            m_ov        = 1'b0;
            mdl_deliver = 1'b0;
            if (evq.size() > 0 && evq[0].t == tick) begin
                mdl_ev = evq.pop_front();
                if (mdl_ev.stop) mdl_deliver = 1'b1;
                else             m_ferr      = 1'b1;
            end
            if (mdl_deliver) begin
                if (!m_valid || rx_ready) begin
                    m_data  = mdl_ev.w;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (rx_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    bit started    = 1'b0;
    int n_cmp      = 0;
    int n_err      = 0;
    int valid_cyc  = 0;
    int rises      = 0;
    int ferr_cnt   = 0;
    int ov_cnt     = 0;
    int rise_tick  = 0;
    bit prev_valid = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            n_cmp++;
            if (rx_valid !== m_valid || rx_data !== m_data ||
                rx_frame_err !== m_ferr || rx_overrun !== m_ov) begin
                n_err++;
                $display("FAIL cycle tick=%0d: got v=%b d=%h fe=%b ov=%b, expected v=%b d=%h fe=%b ov=%b",
                         tick, rx_valid, rx_data, rx_frame_err, rx_overrun,
                         m_valid, m_data, m_ferr, m_ov);
            end
            if (rx_valid === 1'b1) valid_cyc++;
            if (rx_valid === 1'b1 && !prev_valid) begin
                rises++;
                rise_tick = tick;
            end
            prev_valid = (rx_valid === 1'b1);
            if (rx_frame_err === 1'b1) ferr_cnt++;
            if (rx_overrun === 1'b1) ov_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_stats();
        valid_cyc = 0;
        rises     = 0;
        ferr_cnt  = 0;
        ov_cnt    = 0;
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = tick + n;
        while (tick < target) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input int glitch_at);
        rx_signal = b;
        if (glitch_at >= 0) begin
            wait_ticks(glitch_at);
            rx_signal = ~b;
            wait_ticks(1);
            rx_signal = b;
            wait_ticks(P - glitch_at - 1);
        end else begin
            wait_ticks(P);
        end
    endtask

    // nbits frame bits are driven; only a complete frame is scheduled in the model.
    task automatic send_frame(input logic [DW-1:0] w, input logic stop,
                              input int nbits, input int glitch_bit);
        logic b;
        int   g;
        if (nbits == DW + 2) evq.push_back('{t: tick + LAT, w: w, stop: stop});
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)       b = 1'b0;
            else if (i <= DW) b = w[i-1];
            else              b = stop;
            g = (i >= 1 && i <= DW && glitch_bit == i - 1) ? H - 1 : -1;
            drive_bit(b, g);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    int t0;

    initial begin
        repeat (3) @(negedge clk);
        started = 1'b1;
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_ferr", rx_frame_err, 0);
        check("reset_ovr", rx_overrun, 0);
        reset_n = 1'b1;
        wait_ticks(20);

        clear_stats();
        t0 = tick;
        send_frame(8'hA5, 1'b1, DW + 2, -1);
        wait_ticks(30);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid_cycles", valid_cyc, 1);
        check("a5_latency", rise_tick - t0, 4126);
        check("a5_ferr", ferr_cnt, 0);
        check("a5_ovr", ov_cnt, 0);

        clear_stats();
        rx_signal = 1'b0;
        wait_ticks(100);
        rx_signal = 1'b1;
        wait_ticks(600);
        check("false_start_valid", rises, 0);
        check("false_start_ferr", ferr_cnt, 0);

        clear_stats();
        send_frame(8'h3C, 1'b0, DW + 2, -1);
        wait_ticks(2000);
        rx_signal = 1'b1;
        wait_ticks(50);
        check("break_ferr", ferr_cnt, 1);
        check("break_valid", rises, 0);
        check("break_data_kept", rx_data, 8'hA5);

        clear_stats();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, DW + 2, -1);
        send_frame(8'h22, 1'b1, DW + 2, -1);
        wait_ticks(30);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_pulses", ov_cnt, 1);
        rx_ready = 1'b1;
        wait_ticks(5);
        check("ovr_drained", rx_valid, 0);

        clear_stats();
        fork
            send_frame(8'h81, 1'b1, DW + 2, -1);
            begin
                wait_ticks(3 * P);
                ena = 1'b0;
                repeat (50) @(negedge clk);
                ena = 1'b1;
            end
        join
        wait_ticks(30);
        check("ena_data", rx_data, 8'h81);
        check("ena_rises", rises, 1);
        check("ena_ferr", ferr_cnt, 0);

        clear_stats();
        send_frame(8'hC3, 1'b1, 5, -1);
        rx_signal = 1'b0;
        wait_ticks(H);
        reset_n   = 1'b0;
        rx_signal = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset_data", rx_data, 0);
        check("midreset_valid", rx_valid, 0);
        reset_n = 1'b1;
        wait_ticks(20);
        send_frame(8'h5A, 1'b1, DW + 2, -1);
        wait_ticks(30);
        check("midreset_frame", rx_data, 8'h5A);
        check("midreset_rises", rises, 1);
        check("midreset_ferr", ferr_cnt, 0);

`ifdef UART_RX_MAJORITY_EN
        clear_stats();
        send_frame(8'h81, 1'b1, DW + 2, 0);
        wait_ticks(30);
        check("glitch_data", rx_data, 8'h81);
        check("glitch_rises", rises, 1);
`endif

        summary();
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout at tick %0d, expected completion", tick);
        summary();
        $finish;
    end

endmodule
`default_nettype wire
